// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB write arbiter.
// Default timings assume a 50 MHz system clock.
package sccb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] SCCB_WR_ADDR = 8'h42;

    localparam int TIMEOUT_CYC_DEF = 5_000_000;
    localparam int GAP_CYC_DEF     = 50_000;
    localparam int CNT_W_DEF       = 23;

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// The pulse appears three clocks after the raw input rises.
module sync_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [2:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= 3'b000;
            rise <= 1'b0;
        end else begin
            sh   <= {sh[1:0], din};
            rise <= sh[1] & ~sh[2];
        end
    end

endmodule

// File: rtl/sccb_req_arbiter.sv
// Round-robin share of one SCCB write transmitter between the power-up
// register sequencer (0) and the runtime tuning writer (1).
module sccb_req_arbiter
    import sccb_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int GAP_CYC     = GAP_CYC_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ0,
    input  logic [23:0] DATA0,
    output logic        ACK0,
    output logic        ERR0,
    input  logic        REQ1,
    input  logic [23:0] DATA1,
    output logic        ACK1,
    output logic        ERR1,
    output logic        I2C_EN,
    output logic [23:0] I2C_DATA,
    input  logic        I2C_TDONE,
    output logic [1:0]  GRANT,
    output logic        BUSY
);

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx, cnt_inc;
    logic              last, last_nx;
    logic [1:0]        grant, grant_nx;
    logic [23:0]       data_q, data_nx;
    logic [1:0]        ack_q, ack_nx;
    logic [1:0]        err_q, err_nx;
    logic              pick1;
    logic              done_evt;

    sync_rise_det u_done (
        .clk   (CLK),
        .rst_n (RST_N),
        .din   (I2C_TDONE),
        .rise  (done_evt)
    );

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        last_nx  = last;
        grant_nx = grant;
        data_nx  = data_q;
        ack_nx   = 2'b00;
        err_nx   = 2'b00;
        // On a tie the requester that did not win last time goes next.
        pick1    = REQ1 & (~REQ0 | ~last);
        unique case (state)
            IDLE: begin
                if (REQ0 | REQ1) begin
                    state_nx = XFER;
                    cnt_nx   = '0;
                    last_nx  = pick1;
                    grant_nx = pick1 ? 2'b10 : 2'b01;
                    data_nx  = pick1 ? DATA1 : DATA0;
                end
            end
            XFER: begin
                cnt_nx = cnt_inc;
                if (done_evt || cnt >= TO_LAST) begin
                    state_nx = GAP;
                    cnt_nx   = '0;
                    grant_nx = 2'b00;
                    if (done_evt) ack_nx = grant;
                    else          err_nx = grant;
                end
            end
            GAP: begin
                cnt_nx = cnt_inc;
                if (cnt >= GAP_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            cnt    <= '0;
            last   <= 1'b1;
            grant  <= 2'b00;
            data_q <= '0;
            ack_q  <= 2'b00;
            err_q  <= 2'b00;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            last   <= last_nx;
            grant  <= grant_nx;
            data_q <= data_nx;
            ack_q  <= ack_nx;
            err_q  <= err_nx;
        end
    end

    // Enable and busy follow the state register so reset clears them at once.
    assign I2C_EN   = (state == XFER);
    assign BUSY     = (state != IDLE);
    assign GRANT    = grant;
    assign I2C_DATA = data_q;
    assign ACK0     = ack_q[0];
    assign ACK1     = ack_q[1];
    assign ERR0     = err_q[0];
    assign ERR1     = err_q[1];

endmodule

// File: doc/sccb_req_arbiter.md
Name: sccb_req_arbiter

Overview:
- Shares the single SCCB/I2C write transmitter (24-bit {dev_addr, reg_addr, reg_data}, EN level in, T_DONE pulse out) between two requesters.
- Requester 0 is the power-up register-table sequencer. Requester 1 is the runtime tuning writer (exposure/gain/mirror updates).
- The block grants the transmitter round-robin, runs exactly one write per grant, and detects completion or timeout.
- It enforces a minimum bus gap between writes and returns a per-requester ACK/ERR pulse.

Parameters:
- TIMEOUT_CYC, 5_000_000, CLK cycles allowed from I2C_EN rise to detected done (100 ms at 50 MHz); minimum 16.
- GAP_CYC, 50_000, idle CLK cycles enforced after every write (done or timeout) before the next grant; minimum 1.
- CNT_W, 23, width of the shared timeout/gap counter; must hold max(TIMEOUT_CYC, GAP_CYC).

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- REQ0  in  1  requester 0 write request (level)
- DATA0  in  24  requester 0 write word
- ACK0  out  1  1-cycle pulse: requester 0 write completed
- ERR0  out  1  1-cycle pulse: requester 0 write timed out
- REQ1  in  1  requester 1 write request (level)
- DATA1  in  24  requester 1 write word
- ACK1  out  1  1-cycle pulse: requester 1 write completed
- ERR1  out  1  1-cycle pulse: requester 1 write timed out
- I2C_EN  out  1  enable to transmitter, held high for exactly one transfer
- I2C_DATA  out  24  word to transmitter
- I2C_TDONE  in  1  transmitter done, raw from the divided I2C clock domain
- GRANT  out  2  one-hot current owner, 00 when no owner
- BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset: clock and reset are one clock, CLK, and RST_N (asynchronous, active-low).
  - Reset forces state IDLE and sets every output to 0: I2C_EN, I2C_DATA, GRANT, BUSY, ACKx and ERRx.
  - Counter is cleared and the synchronizer flops are cleared.
  - Round-robin pointer last=1, so REQ0 wins the first tie.
- Reset mid-transfer: I2C_EN drops immediately (asynchronous). No ACK or ERR is issued for the aborted write.
- I2C_TDONE handling: 2-FF synchronizer, then rising-edge detect. The registered done_evt pulse fires 3 CLK cycles after the raw rise. A level held high produces one event only.
- States: IDLE, XFER, GAP.
- IDLE:
  - If any REQx is high, grant per round-robin: the requester other than last wins a tie.
  - On grant: latch DATAx into I2C_DATA, set GRANT one-hot, set last to the winner, load the counter with 0, and go to XFER.
  - I2C_EN and BUSY are high from the next cycle. Latency from REQ sampled high to I2C_EN high is 1 cycle.
  - done_evt arriving in IDLE or GAP is discarded.
- XFER:
  - I2C_EN=1. I2C_DATA holds stable and ignores later DATAx changes. The counter increments.
  - done_evt: pulse ACK of the owner in the next cycle, drop I2C_EN, clear GRANT, load the counter with 0, and go to GAP.
  - Counter reaches TIMEOUT_CYC-1 without done_evt: pulse ERR of the owner and otherwise do the same as done_evt.
  - done_evt and timeout in the same cycle: done wins, so ACK is issued and ERR is not.
  - The owner dropping REQ during XFER does not abort the transfer; the ACK or ERR pulse still fires.
- GAP:
  - I2C_EN=0, BUSY=1. The counter counts to GAP_CYC-1, then the block returns to IDLE.
  - The earliest next I2C_EN rise is GAP_CYC+1 cycles after the ACK/ERR cycle.
- Requester contract: hold REQx and DATAx until ACKx/ERRx, then deassert REQx within GAP_CYC cycles. A REQx still high on return to IDLE is a new request.
- ACKx and ERRx are never high together and never high for a non-owner.
- Counter: a single CNT_W-bit counter shared by XFER and GAP. It saturates and never wraps.

Decomposition:
- Shared package sccb_pkg:
  - State encoding localparams (IDLE=2'd0, XFER=2'd1, GAP=2'd2).
  - SCCB_WR_ADDR=8'h42.
  - Default TIMEOUT_CYC and GAP_CYC constants.
- One sub-module: sync_rise_det (2-FF synchronizer plus registered rising-edge pulse, async active-low reset), instantiated for I2C_TDONE.

Test Plan (TIMEOUT_CYC=200, GAP_CYC=10; model transmitter raises TDONE 50 cycles after EN rise):
- Single write:
  - Stimulus: REQ0=1, DATA0=24'h421280.
  - Required: I2C_EN rises 1 cycle later with I2C_DATA=24'h421280 and GRANT=01; ACK0 pulses once.
  - Required: I2C_EN is low in the ACK cycle; the next grant is no earlier than 11 cycles after ACK.
- Tie after reset:
  - Stimulus: REQ0 and REQ1 both high in the same cycle.
  - Required: grant order 0,1,0,1 over four writes; GRANT is never 11.
- Timeout:
  - Stimulus: model never raises TDONE.
  - Required: I2C_EN high for exactly 200 cycles, ERR1 pulses once, ACK1 stays 0, BUSY is held through the 10 gap cycles.
- Simultaneous done and timeout:
  - Stimulus: TDONE timed so done_evt coincides with count 199.
  - Required: ACK pulses, ERR does not.
- Stray done and level done:
  - Stimulus: TDONE pulse while IDLE → no ACK and no state change.
  - Stimulus: TDONE held high for 20 cycles during XFER → exactly one ACK.
- Reset mid-XFER:
  - Stimulus: RST_N low 30 cycles after I2C_EN rise.
  - Required: I2C_EN, GRANT and BUSY drop without waiting for CLK; no ACK or ERR. After release, a pending REQ1 and REQ0 tie grants REQ0 first.
